instr_fifo: RTL and testbench

- Parametrised circular-buffer instruction FIFO, successor to the fetch-side instruction queue.
- Sits between instruction fetch (producer, `put`) and decode (consumer, `get`). Everything runs on one clock domain.
- Adds over the previous queue:
  - true read/write pointers with wrap-around
  - defined simultaneous put/get behaviour
  - occupancy count and almost-full threshold
  - registered read-data valid strobe
  - sticky overflow/underflow error flags
  - synchronous flush plus asynchronous reset

---
 rtl/instr_fifo.sv | 98 +++++++++
 tb/tb_instr_fifo.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/instr_fifo.sv
// Circular-buffer instruction queue between fetch (put) and decode (get).
// Pointers carry one extra wrap bit so full and empty can be told apart.
module instr_fifo #(
  parameter int INSTR_WIDTH         = 12,
  parameter int QUEUE_DEPTH         = 8,
  parameter int QUEUE_POINTER_WIDTH = 3,
  parameter int AFULL_THRESH        = 6
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           put,
  input  logic [INSTR_WIDTH-1:0]         d_in,
  input  logic                           get,
  output logic [INSTR_WIDTH-1:0]         d_out,
  output logic                           d_valid,
  output logic                           empty,
  output logic                           full,
  output logic                           almost_full,
  output logic [QUEUE_POINTER_WIDTH:0]   count,
  output logic                           overflow,
  output logic                           underflow
);

  localparam int PW = QUEUE_POINTER_WIDTH;

  logic [INSTR_WIDTH-1:0] mem_q [QUEUE_DEPTH];
  logic [PW:0]            wr_ptr_q, wr_ptr_d;
  logic [PW:0]            rd_ptr_q, rd_ptr_d;
  logic [INSTR_WIDTH-1:0] d_out_q, d_out_d;
  logic                   d_valid_q, d_valid_d;
  logic                   overflow_q, overflow_d;
  logic                   underflow_q, underflow_d;
  logic                   put_ok, get_ok;

  // Status is decoded from the registered pointers only.
  assign count       = wr_ptr_q - rd_ptr_q;
  assign empty       = (count == '0);
  assign full        = (count == (PW+1)'(QUEUE_DEPTH));
  assign almost_full = (count >= (PW+1)'(AFULL_THRESH));

  assign put_ok = put & ~full;
  assign get_ok = get & ~empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    d_out_d     = d_out_q;
    d_valid_d   = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      d_out_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (put_ok) wr_ptr_d = wr_ptr_q + (PW+1)'(1);
      if (put && full) overflow_d = 1'b1;
      if (get_ok) begin
        d_out_d   = mem_q[rd_ptr_q[PW-1:0]];
        rd_ptr_d  = rd_ptr_q + (PW+1)'(1);
        d_valid_d = 1'b1;
      end
      if (get && empty) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      d_out_q     <= '0;
      d_valid_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      d_out_q     <= d_out_d;
      d_valid_q   <= d_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (put_ok && !flush) mem_q[wr_ptr_q[PW-1:0]] <= d_in;
  end

  assign d_out     = d_out_q;
  assign d_valid   = d_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_instr_fifo.sv
// Directed bench for instr_fifo: a vector table for fill/drain/error cases,
// plus hand-written sequences for simultaneous access, wrap-around and flush.
module tb_instr_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, put, get;
  logic [11:0] d_in;
  logic [11:0] d_out;
  logic        d_valid, empty, full, almost_full, overflow, underflow;
  logic [3:0]  count;

  int n_chk  = 0;
  int n_fail = 0;

  instr_fifo #(
    .INSTR_WIDTH(12), .QUEUE_DEPTH(8), .QUEUE_POINTER_WIDTH(3), .AFULL_THRESH(6)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .put(put), .d_in(d_in), .get(get),
    .d_out(d_out), .d_valid(d_valid), .empty(empty), .full(full),
    .almost_full(almost_full), .count(count), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl, p, g;
    logic [11:0] d;
    logic [3:0]  cnt;
    logic        dv;
    logic [11:0] dout;
    logic        emp, ful, af, ovf, udf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int fl, int p, int g, int d, int cnt, int dv, int dout,
                              int emp, int ful, int af, int ovf, int udf);
    vec_t v;
    v.fl = 1'(fl); v.p = 1'(p); v.g = 1'(g); v.d = 12'(d);
    v.cnt = 4'(cnt); v.dv = 1'(dv); v.dout = 12'(dout);
    v.emp = 1'(emp); v.ful = 1'(ful); v.af = 1'(af); v.ovf = 1'(ovf); v.udf = 1'(udf);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive at the falling edge, then sample just after the following rising edge.
  task automatic cyc(input logic fl, input logic p, input logic g, input logic [11:0] d);
    @(negedge clk);
    flush = fl; put = p; get = g; d_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    flush = 1'b0; put = 1'b0; get = 1'b0; d_in = '0;
  endtask

  task automatic check_all(input string tag, input vec_t v);
    chk({tag, " count"},       32'(count),       32'(v.cnt));
    chk({tag, " d_valid"},     32'(d_valid),     32'(v.dv));
    chk({tag, " d_out"},       32'(d_out),       32'(v.dout));
    chk({tag, " empty"},       32'(empty),       32'(v.emp));
    chk({tag, " full"},        32'(full),        32'(v.ful));
    chk({tag, " almost_full"}, 32'(almost_full), 32'(v.af));
    chk({tag, " overflow"},    32'(overflow),    32'(v.ovf));
    chk({tag, " underflow"},   32'(underflow),   32'(v.udf));
  endtask

  initial begin
    //             fl p g  d      cnt dv dout   emp ful af ovf udf
    tbl.push_back(mk(0,1,0,'h001, 1, 0,'h000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0,1,0,'h002, 2, 0,'h000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0,1,0,'h003, 3, 0,'h000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0,1,0,'h004, 4, 0,'h000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0,1,0,'h005, 5, 0,'h000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0,1,0,'h006, 6, 0,'h000, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0,1,0,'h007, 7, 0,'h000, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0,1,0,'h008, 8, 0,'h000, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0,1,0,'h0AA, 8, 0,'h000, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0,0,1,'h000, 7, 1,'h001, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0,0,1,'h000, 6, 1,'h002, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0,0,1,'h000, 5, 1,'h003, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0,0,1,'h000, 4, 1,'h004, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0,0,1,'h000, 3, 1,'h005, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0,0,1,'h000, 2, 1,'h006, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0,0,1,'h000, 1, 1,'h007, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0,0,1,'h000, 0, 1,'h008, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0,1,1,'h123, 1, 0,'h008, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0,0,1,'h000, 0, 1,'h123, 1, 0, 0, 1, 1));
    tbl.push_back(mk(1,0,0,'h000, 0, 0,'h000, 1, 0, 0, 0, 0));

    rst_n = 1'b0; flush = 1'b0; put = 1'b0; get = 1'b0; d_in = '0;
    repeat (2) @(negedge clk);
    check_all("reset", mk(0,0,0,0, 0,0,0, 1,0,0,0,0));
    rst_n = 1'b1;

    // Asynchronous reset dropped between edges while the queue holds data.
    cyc(1'b0, 1'b1, 1'b0, 12'h055);
    cyc(1'b0, 1'b1, 1'b0, 12'h066);
    cyc(1'b0, 1'b0, 1'b1, 12'h000);
    chk("pre-reset d_out", 32'(d_out), 32'h055);
    rst_n = 1'b0;
    #1;
    check_all("async reset", mk(0,0,0,0, 0,0,0, 1,0,0,0,0));
    @(negedge clk);
    rst_n = 1'b1; put = 1'b0; get = 1'b0;

    foreach (tbl[i]) begin
      cyc(tbl[i].fl, tbl[i].p, tbl[i].g, tbl[i].d);
      check_all($sformatf("row%0d", i), tbl[i]);
    end

    // Simultaneous put/get at count 3, then the full boundary.
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b0, 12'(32'h201 + k));
    chk("sim pre count", 32'(count), 3);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b1, 1'b1, 12'(32'h204 + k));
      chk($sformatf("sim%0d count", k), 32'(count), 3);
      chk($sformatf("sim%0d d_out", k), 32'(d_out), 32'h201 + k);
      chk($sformatf("sim%0d d_valid", k), 32'(d_valid), 1);
    end
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 1'b0, 12'(32'h208 + k));
    chk("fullb pre full", 32'(full), 1);
    chk("fullb pre overflow", 32'(overflow), 0);
    cyc(1'b0, 1'b1, 1'b1, 12'h0BB);
    chk("fullb count", 32'(count), 7);
    chk("fullb d_out", 32'(d_out), 32'h205);
    chk("fullb overflow", 32'(overflow), 1);
    chk("fullb full", 32'(full), 0);
    for (int k = 0; k < 7; k++) begin
      cyc(1'b0, 1'b0, 1'b1, 12'h000);
      chk($sformatf("drain%0d d_out", k), 32'(d_out), 32'h206 + k);
    end
    chk("drain empty", 32'(empty), 1);

    // Wrap-around: 40 words streamed through a one-deep occupancy.
    for (int k = 0; k <= 40; k++) begin
      cyc(1'b0, 1'(k < 40), 1'(k >= 1), 12'(k));
      chk($sformatf("wrap%0d count", k), 32'(count), (k < 40) ? 1 : 0);
      chk($sformatf("wrap%0d d_valid", k), 32'(d_valid), (k >= 1) ? 1 : 0);
      if (k >= 1) chk($sformatf("wrap%0d d_out", k), 32'(d_out), k - 1);
    end
    chk("wrap underflow", 32'(underflow), 0);

    // Flush with put and get pending, both error flags set.
    cyc(1'b0, 1'b0, 1'b1, 12'h000);
    for (int k = 0; k < 8; k++) cyc(1'b0, 1'b1, 1'b0, 12'(32'h301 + k));
    cyc(1'b0, 1'b1, 1'b0, 12'h3FF);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b1, 12'h000);
    chk("preflush count", 32'(count), 5);
    chk("preflush overflow", 32'(overflow), 1);
    chk("preflush underflow", 32'(underflow), 1);
    chk("preflush d_out", 32'(d_out), 32'h303);
    cyc(1'b1, 1'b1, 1'b1, 12'h3AA);
    check_all("flush", mk(0,0,0,0, 0,0,0, 1,0,0,0,0));
    cyc(1'b0, 1'b1, 1'b0, 12'h3C3);
    chk("postflush count", 32'(count), 1);
    cyc(1'b0, 1'b0, 1'b1, 12'h000);
    chk("postflush d_out", 32'(d_out), 32'h3C3);
    chk("postflush d_valid", 32'(d_valid), 1);
    chk("postflush empty", 32'(empty), 1);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
